cpu_control_unit: RTL and testbench
===================================

// Module: cpu_control_unit
// PURPOSE
//  Control unit of the 16-bit CPU: program counter, instruction register and the
//  fetch/decode/execute FSM. Addresses an external synchronous instruction ROM
//  (registered address, 1-cycle latency) and drives data-memory, register-file
//  and ALU control. Each instruction runs Fetch -> Decode -> execute state(s).
// PARAMETERS
//  PC_W    7   program counter / ROM address width
//  INSTR_W 16  instruction width
// PORTS
//  Clk         in  1   clock; all state updates on rising edge
//  Rst         in  1   reset; synchronous, active-high
//  instruction in  16  ROM output word for the address registered at the previous edge
//  PC_Out      out 7   program counter (ROM address)
//  IR_Out      out 16  instruction register
//  OutState    out 4   current FSM state
//  NextState   out 4   combinational next FSM state
//  D_Addr      out 8   data-memory address
//  D_Wr        out 1   data-memory write enable
//  RF_s        out 1   RF write-data select: 1 = data memory, 0 = ALU
//  RF_W_en     out 1   RF write enable
//  RF_Ra_Addr  out 4   RF read port A address
//  RF_Rb_Addr  out 4   RF read port B address
//  RF_W_Addr   out 4   RF write address
//  ALU_s0      out 3   ALU op: 0 pass/none, 1 add, 2 sub
// BEHAVIOUR
//  Reset: state=Init, PC=0, IR=0; while Rst=1 no other update.
//  States: Init=0 Fetch=1 Decode=2 Noop=3 LoadA=4 LoadB=5 Store=6 Add=7 Sub=8 Halt=9.
//  Opcode IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6-15 = NOOP.
//  Transitions: Init->Fetch; Fetch->Decode; Decode->by opcode (Noop/Store/LoadA/Add/Sub/Halt);
//   LoadA->LoadB->Fetch; Noop/Store/Add/Sub->Fetch; Halt->Halt until Rst.
//  PC: cleared when PC_Clr (Init) or Rst; +1 when PC_Up (Fetch); 127 wraps to 0; else holds.
//  IR: loads instruction at edge ending Fetch (IR_Ld); otherwise holds.
//  Outputs (Moore, from state and IR); all default 0 in every state not listed:
//   Init : PC_Clr=1.  Fetch: IR_Ld=1, PC_Up=1.  Decode/Noop/Halt: none.
//   LoadA: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0].
//   LoadB: as LoadA plus RF_W_en=1 (memory read latency of 1 cycle absorbed by LoadA).
//   Store: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], D_Wr=1.
//   Add  : RF_Ra=IR[11:8], RF_Rb=IR[7:4], RF_W_Addr=IR[3:0], ALU_s0=1, RF_W_en=1, RF_s=0.
//   Sub  : as Add with ALU_s0=2.
//  ROM timing: PC=0 after reset, so the ROM registers address 0 during Init and
//   instruction is valid in Fetch; each later PC increment precedes the next Fetch by
//   >=2 edges, so instruction is always valid in Fetch.
//  Rst asserted mid-instruction (any state incl. Halt): next edge state=Init, PC=0, IR=0.
//  NextState equals the value OutState takes at the next edge (Rst overrides to Init).
// STRUCTURE
//  Shared package cpu_pkg: state enum (4-bit encodings above), opcode constants,
//   ALU select constants (ALU_PASS=0, ALU_ADD=1, ALU_SUB=2).
//  One sub-module: pc_counter (7-bit Clr/Up counter). IR register and FSM inline.
// TESTING
//  Rst=1 one cycle -> OutState=0, PC_Out=0, IR_Out=0; all control outputs 0.
//  ROM[0]=16'h2_1B_3 (LOAD) -> states 0,1,2,4,5,1; in LoadB D_Addr=8'h1B, RF_W_Addr=3, RF_s=1, RF_W_en=1; PC=1.
//  ROM[1]=16'h3_1_2_4 (ADD) -> Add state: Ra=1, Rb=2, W=4, ALU_s0=1, RF_W_en=1, RF_s=0.
//  ROM[2]=16'h1_5_40 (STORE), ROM[3]=16'h4_6_7_8 (SUB) -> Store: D_Addr=8'h40, Ra=5, D_Wr=1; Sub: ALU_s0=2.
//  ROM[4]=16'h5000 (HALT) -> OutState stays 9, PC stays 5 for 10 cycles; Rst -> Init, PC=0.
//  PC=127 after Fetch of NOOP (opcode 0/15) -> PC wraps to 0, Noop->Fetch, no writes asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and ALU-select definitions for the CPU control unit
package cpu_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/cpu_control_unit_pc_counter.sv
// rtl/cpu_control_unit_pc_counter.sv - program counter with clear and increment, wraps at the top
module pc_counter #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         up_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (up_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - fetch/decode/execute FSM, instruction register and datapath control
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 7,
    parameter int INSTR_W = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    PC_Out,
    output logic [INSTR_W-1:0] IR_Out,
    output logic [3:0]         OutState,
    output logic [3:0]         NextState,
    output logic [7:0]         D_Addr,
    output logic               D_Wr,
    output logic               RF_s,
    output logic               RF_W_en,
    output logic [3:0]         RF_Ra_Addr,
    output logic [3:0]         RF_Rb_Addr,
    output logic [3:0]         RF_W_Addr,
    output logic [2:0]         ALU_s0
);

    state_t             state_q;
    state_t             state_d;
    logic [INSTR_W-1:0] ir_q;
    logic               pc_clr;
    logic               pc_up;
    logic               ir_ld;

    pc_counter #(.W(PC_W)) u_pc (
        .clk_i (Clk),
        .rst_i (Rst),
        .clr_i (pc_clr),
        .up_i  (pc_up),
        .pc_o  (PC_Out)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_ld) begin
                ir_q <= instruction;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ir_q[15:12])
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOADA;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOADA:  state_d = S_LOADB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        if (Rst) begin
            state_d = S_INIT;
        end
    end

    // Moore outputs: every control line is idle unless the current state drives it
    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        D_Addr     = 8'd0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'd0;
        RF_Rb_Addr = 4'd0;
        RF_W_Addr  = 4'd0;
        ALU_s0     = ALU_PASS;
        case (state_q)
            S_INIT:  pc_clr = 1'b1;
            S_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            S_LOADA, S_LOADB: begin
                D_Addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = ir_q[3:0];
                RF_W_en   = (state_q == S_LOADB);
            end
            S_STORE: begin
                D_Addr     = ir_q[7:0];
                RF_Ra_Addr = ir_q[11:8];
                D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = ir_q[11:8];
                RF_Rb_Addr = ir_q[7:4];
                RF_W_Addr  = ir_q[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign IR_Out    = ir_q;
    assign OutState  = state_q;
    assign NextState = state_d;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - randomized self-checking bench against an instruction-level model
module tb_cpu_control_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] instruction;
    logic [6:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  OutState;
    logic [3:0]  NextState;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [3:0]  RF_W_Addr;
    logic [2:0]  ALU_s0;

    always #5 Clk = ~Clk;

    cpu_control_unit dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .instruction(instruction),
        .PC_Out     (PC_Out),
        .IR_Out     (IR_Out),
        .OutState   (OutState),
        .NextState  (NextState),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .RF_W_Addr  (RF_W_Addr),
        .ALU_s0     (ALU_s0)
    );

    logic [15:0] rom [128];

    always @(posedge Clk) instruction <= rom[PC_Out];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: one state per cycle, future states of the current instruction queued at fetch time
    int          m_state;
    int          m_pc;
    logic [15:0] m_ir;
    int          q[$];

    function automatic int peek_next();
        if (q.size() > 0) return q[0];
        if (m_state == 9) return 9;
        return 1;
    endfunction

    task automatic advance(input logic rst);
        int nx;
        logic [3:0] op;
        if (rst) begin
            m_state = 0;
            m_pc    = 0;
            m_ir    = 16'd0;
            q.delete();
            return;
        end
        nx = peek_next();
        if (q.size() > 0) void'(q.pop_front());
        if (m_state == 1) begin
            m_ir = rom[m_pc];
            m_pc = (m_pc + 1) % 128;
        end
        if (nx == 1) begin
            op = rom[m_pc][15:12];
            q.push_back(2);
            case (op)
                4'd1: q.push_back(6);
                4'd2: begin q.push_back(4); q.push_back(5); end
                4'd3: q.push_back(7);
                4'd4: q.push_back(8);
                4'd5: q.push_back(9);
                default: q.push_back(3);
            endcase
        end
        m_state = nx;
    endtask

    task automatic check_all();
        logic [7:0] e_daddr;
        logic       e_dwr, e_rfs, e_wen;
        logic [3:0] e_ra, e_rb, e_wa;
        logic [2:0] e_alu;
        e_daddr = 0; e_dwr = 0; e_rfs = 0; e_wen = 0;
        e_ra = 0; e_rb = 0; e_wa = 0; e_alu = 0;
        case (m_state)
            4, 5: begin
                e_daddr = m_ir[11:4];
                e_rfs   = 1'b1;
                e_wa    = m_ir[3:0];
                e_wen   = (m_state == 5);
            end
            6: begin
                e_daddr = m_ir[7:0];
                e_ra    = m_ir[11:8];
                e_dwr   = 1'b1;
            end
            7, 8: begin
                e_ra  = m_ir[11:8];
                e_rb  = m_ir[7:4];
                e_wa  = m_ir[3:0];
                e_wen = 1'b1;
                e_alu = (m_state == 7) ? 3'd1 : 3'd2;
            end
            default: ;
        endcase
        check("state", 32'(OutState), 32'(m_state));
        check("next_state", 32'(NextState), Rst ? 32'd0 : 32'(peek_next()));
        check("pc", 32'(PC_Out), 32'(m_pc));
        check("ir", 32'(IR_Out), 32'(m_ir));
        check("d_addr", 32'(D_Addr), 32'(e_daddr));
        check("d_wr", 32'(D_Wr), 32'(e_dwr));
        check("rf_s", 32'(RF_s), 32'(e_rfs));
        check("rf_w_en", 32'(RF_W_en), 32'(e_wen));
        check("rf_ra", 32'(RF_Ra_Addr), 32'(e_ra));
        check("rf_rb", 32'(RF_Rb_Addr), 32'(e_rb));
        check("rf_wa", 32'(RF_W_Addr), 32'(e_wa));
        check("alu_s0", 32'(ALU_s0), 32'(e_alu));
    endtask

    task automatic cycle(input logic rst);
        @(negedge Clk);
        Rst = rst;
        #1;
        check_all();
        @(posedge Clk);
        advance(rst);
    endtask

    task automatic first_reset();
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        advance(1'b1);
    endtask

    initial begin
        Rst = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h21B3;
        rom[1] = 16'h3124;
        rom[2] = 16'h1540;
        rom[3] = 16'h4678;
        rom[4] = 16'h5000;

        // Directed program: LOAD, ADD, STORE, SUB, HALT
        first_reset();
        for (int c = 0; c < 32; c++) cycle(1'b0);
        @(negedge Clk);
        #1;
        check("halt_state", 32'(OutState), 32'd9);
        check("halt_pc", 32'(PC_Out), 32'd5);
        cycle(1'b1);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("post_halt_rst_state", 32'(OutState), 32'd0);
        check("post_halt_rst_pc", 32'(PC_Out), 32'd0);

        // Long HALT-free program so the PC wraps past 127
        for (int i = 0; i < 128; i++) begin
            rom[i] = 16'($urandom);
            if (rom[i][15:12] == 4'd5) rom[i][15:12] = 4'd15;
        end
        first_reset();
        for (int c = 0; c < 700; c++) cycle(1'b0);

        // Random programs including HALT, with occasional mid-instruction resets
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
            first_reset();
            for (int c = 0; c < 300; c++) cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
